// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture pair: counter width and
// the capture FSM state encoding.
package pwm_pkg;

    localparam int unsigned PWM_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pwm_cap_state_e;

endpackage : pwm_pkg

// File: rtl/pwm_sync_edge.sv
// Multi-flop synchronizer for an asynchronous line, followed by a
// previous-level flop that yields single-cycle rise/fall strobes.
module pwm_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    // Ones shift in after reset; edges are only trusted once the whole chain
    // holds real samples, so a line already high at release is not a rise.
    logic [SYNC_STAGES:0]   primed_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            prev_q   <= 1'b0;
            primed_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q   <= sync_q[SYNC_STAGES-1];
            primed_q <= {primed_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = primed_q[SYNC_STAGES] & level_o & ~prev_q;
    assign fall_o  = primed_q[SYNC_STAGES] & ~level_o & prev_q;

endmodule : pwm_sync_edge

// File: rtl/pwm_capture.sv
// PWM decoder: measures rise-to-rise period and rise-to-fall high time in
// clock cycles, and flags a line that stops producing rising edges.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = PWM_CNT_WIDTH,
    parameter int unsigned TIMEOUT     = 32'hFFFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 pwm_i,
    output logic [CNT_WIDTH-1:0] meas_period_o,
    output logic [CNT_WIDTH-1:0] meas_duty_o,
    output logic                 valid_o,
    output logic                 stuck_o,
    output logic                 stuck_lvl_o
);

    localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT);

    logic level, rise, fall;

    pwm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (pwm_i),
        .level_o(level),
        .rise_o (rise),
        .fall_o (fall)
    );

    pwm_cap_state_e       state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] duty_q, duty_d;
    logic                 valid_q, valid_d;
    logic                 stuck_q, stuck_d;
    logic                 stuck_lvl_q, stuck_lvl_d;
    logic                 at_tmo;

    assign at_tmo = (cnt_q == TMO);

    always_comb begin
        state_d     = state_q;
        cnt_d       = at_tmo ? cnt_q : cnt_q + 1'b1;
        hcnt_d      = hcnt_q;
        period_d    = period_q;
        duty_d      = duty_q;
        valid_d     = 1'b0;
        stuck_d     = stuck_q;
        stuck_lvl_d = stuck_lvl_q;

        if (!en_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            hcnt_d  = '0;
            stuck_d = 1'b0;
        end else begin
            if (rise) begin
                stuck_d = 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        cnt_d   = CNT_WIDTH'(1);
                        state_d = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    // The fall cycle itself belongs to the low phase.
                    if (fall) begin
                        hcnt_d  = cnt_q;
                        state_d = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        period_d = cnt_q;
                        duty_d   = hcnt_q;
                        valid_d  = 1'b1;
                        cnt_d    = CNT_WIDTH'(1);
                        state_d  = ST_HIGH;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            // A rise arriving exactly at the limit still closes the period.
            if (at_tmo && !rise) begin
                stuck_d     = 1'b1;
                stuck_lvl_d = level;
                state_d     = ST_IDLE;
                cnt_d       = '0;
                hcnt_d      = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            period_q    <= '0;
            duty_q      <= '0;
            valid_q     <= 1'b0;
            stuck_q     <= 1'b0;
            stuck_lvl_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            period_q    <= period_d;
            duty_q      <= duty_d;
            valid_q     <= valid_d;
            stuck_q     <= stuck_d;
            stuck_lvl_q <= stuck_lvl_d;
        end
    end

    assign meas_period_o = period_q;
    assign meas_duty_o   = duty_q;
    assign valid_o       = valid_q;
    assign stuck_o       = stuck_q;
    assign stuck_lvl_o   = stuck_lvl_q;

endmodule : pwm_capture

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- PWM capture/decoder: receives an asynchronous PWM line and measures its period and high time in clk_i cycles.
- Receive-side counterpart of pwm_unit; used for loopback checks of the PWM generator and for decoding external PWM inputs (e.g. servo/fan feedback).
- Reports one measurement per complete period and flags a stuck line, low or high, after a programmable timeout.

Parameters:
- CNT_WIDTH, 16: width of the period/duty counters and measurement outputs.
- TIMEOUT, 16'hFFFF: cycles without a rising edge before the line is declared stuck. Legal range 2 .. 2^CNT_WIDTH-1.
- SYNC_STAGES, 2: flip-flop stages in the input synchronizer. Minimum 2.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- rst_ni  input  1  synchronous reset, active-low.
- en_i  input  1  capture enable. Low holds the FSM in IDLE and clears the counters.
- pwm_i  input  1  asynchronous PWM line.
- meas_period_o  output  CNT_WIDTH  last measured period in cycles (rise to rise).
- meas_duty_o  output  CNT_WIDTH  last measured high time in cycles (rise to fall).
- valid_o  output  1  one-cycle pulse; a new meas_* pair is presented this cycle.
- stuck_o  output  1  line has had no rising edge for TIMEOUT cycles.
- stuck_lvl_o  output  1  synchronized line level when stuck_o was set.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - All outputs are 0: meas_period_o, meas_duty_o, valid_o, stuck_o, stuck_lvl_o.
  - FSM goes to IDLE, counters are cleared, synchronizer flops are cleared.
  - Reset mid-measurement discards the partial period; no valid_o is produced for it.
- Input path: SYNC_STAGES-flop synchronizer, then a registered previous-level flop.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Detection latency: SYNC_STAGES+1 cycles. The latency is common to both edges, so measured widths are exact.
- Single counter cnt, which saturates at TIMEOUT and never wraps. The high-time capture register is hcnt.
- FSM states and transitions:
  - IDLE: waiting for the first rise; the first partial period is never reported. cnt increments. On rise: cnt<=1, go to HIGH.
  - HIGH: cnt++.
    - On fall: hcnt<=cnt, go to LOW. The fall cycle is not counted as high.
  - LOW: cnt++.
    - On rise: meas_period_o<=cnt, meas_duty_o<=hcnt, valid_o<=1 next cycle, cnt<=1, go to HIGH.
- Worked example: high for 4 cycles of a 10-cycle period gives meas_period_o=10, meas_duty_o=4.
- valid_o latency: valid_o and the new meas_* values appear on the same clock, one cycle after the closing rise is detected. The meas_* outputs hold their values until the next valid_o.
- Timeout, any state, when cnt==TIMEOUT and no rise this cycle:
  - stuck_o<=1, stuck_lvl_o<=sync level, go to IDLE.
  - meas_* are unchanged and valid_o is not pulsed.
  - stuck_o stays high until the next detected rise, which clears it and starts HIGH.
- Simultaneous events:
  - Rise in the same cycle that cnt==TIMEOUT: the edge wins, a valid measurement with period=TIMEOUT is reported, and there is no stuck.
  - A rise while stuck_o=1 clears stuck_o in that cycle.
- Minimum pulses:
  - A 1-cycle high pulse gives duty=1.
  - A 1-cycle low gap gives period = high+1.
  - duty is 0 only at reset; a stuck line is signalled through stuck_o, never through duty=0.
- en_i low:
  - Same as IDLE entry: counters cleared, stuck_o cleared, meas_* held.
  - The synchronizer keeps running.

Decomposition:
- pwm_pkg shared package:
  - CNT_WIDTH default, shared with pwm_unit.
  - FSM state encoding: IDLE=2'd0, HIGH=2'd1, LOW=2'd2.
- Sub-module pwm_sync_edge (SYNC_STAGES): synchronizer plus rise/fall detector, with outputs level_o, rise_o, fall_o. Reusable by other asynchronous inputs.

Test Plan:
- Reset values: rst_ni=0 for 3 cycles with pwm_i toggling -> all outputs 0 and no valid_o; the first partial period after release is not reported.
- Loopback from pwm_unit, cfg_period=10, cfg_duty=4 -> every valid_o shows meas_period_o=10, meas_duty_o=4, with valid_o spaced 10 cycles apart.
- Change cfg_duty to 7 mid-run, then cfg_period=16 with cfg_duty=8 -> at most one transitional measurement, then 10/7, then 16/8 steady.
- TIMEOUT=32 with pwm_i held 0 -> stuck_o=1 and stuck_lvl_o=0 exactly 32 cycles after the last detected rise; pwm_i held 1 -> stuck_lvl_o=1. A subsequent rise clears stuck_o.
- Single-cycle high pulses every 5 cycles -> meas_period_o=5, meas_duty_o=1.
- Reset asserted mid-HIGH, then released; also en_i dropped mid-period -> no valid_o until a full rise-to-rise period has elapsed after release.
